// File: rtl/mining_pkg.sv
// rtl/mining_pkg.sv - shared types and sizes for the nonce search datapath
package mining_pkg;

  localparam int HDR_WORDS  = 19;
  localparam int HASH_WORDS = 8;
  localparam int MSG_WORDS  = 20;

  typedef enum logic [3:0] {
    IDLE,
    COPY,
    WR_NONCE,
    SHA_GO,
    SHA_ARM,
    SHA_WAIT,
    RD_HASH,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ZC_CONT,
    ZC_PASS,
    ZC_FAIL
  } zc_t;

  // Hash words that must be inspected: ceil(tz/32), never more than the hash holds.
  function automatic logic [3:0] words_needed(input logic [8:0] tz);
    logic [9:0] t;
    t = {1'b0, tz} + 10'd31;
    return (t[9:5] > 5'(HASH_WORDS)) ? 4'(HASH_WORDS) : t[8:5];
  endfunction

endpackage

// File: rtl/hash_zero_check.sv
// rtl/hash_zero_check.sv - per-word leading-zero verdict against the difficulty target
module hash_zero_check #(
  parameter int HASH_WORDS = 8
) (
  input  logic [2:0]  i_word_idx,
  input  logic [31:0] i_word,
  input  logic [8:0]  i_target_zeros,
  output mining_pkg::zc_t o_result
);
  import mining_pkg::*;

  logic [9:0]  w_base;
  logic [9:0]  w_rem;
  logic [5:0]  w_req;
  logic [31:0] w_mask;
  logic        w_word_ok;

  always_comb begin
    // w_rem: zero bits still owed once the earlier words are accounted for
    w_base    = {2'b00, i_word_idx, 5'b00000};
    w_rem     = ({1'b0, i_target_zeros} > w_base) ? ({1'b0, i_target_zeros} - w_base) : 10'd0;
    w_req     = (w_rem > 10'd32) ? 6'd32 : w_rem[5:0];
    w_mask    = ~(32'hFFFF_FFFF >> w_req);
    w_word_ok = ((i_word & w_mask) == 32'd0);
    if (!w_word_ok)
      o_result = ZC_FAIL;
    else if (w_rem <= 10'd32)
      o_result = ZC_PASS;
    else if (i_word_idx == 3'(HASH_WORDS - 1))
      o_result = ZC_FAIL;
    else
      o_result = ZC_CONT;
  end

endmodule

// File: rtl/nonce_search_ctrl.sv
// rtl/nonce_search_ctrl.sv - nonce sweep controller wrapped around the SHA-256 hasher
// Define NONCE_BSWAP_EN to byte-swap the nonce word stored in the message buffer.
module nonce_search_ctrl #(
  parameter int HDR_WORDS  = 19,
  parameter int HASH_WORDS = 8,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] header_addr,
  input  logic [AW-1:0] msg_addr,
  input  logic [AW-1:0] hash_addr,
  input  logic [31:0]   nonce_start,
  input  logic [31:0]   nonce_end,
  input  logic [8:0]    target_zeros,
  output logic          done,
  output logic          found,
  output logic [31:0]   nonce_found,
  output logic [31:0]   hashes_tried,
  output logic          sha_start,
  output logic [AW-1:0] sha_message_addr,
  output logic [AW-1:0] sha_output_addr,
  input  logic          sha_done,
  output logic          sha_grant,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data
);
  import mining_pkg::*;

  state_t        r_state, w_state;
  logic [AW-1:0] r_hdr_addr, r_msg_addr, r_hash_addr;
  logic [31:0]   r_nonce_end;
  logic [8:0]    r_tz;
  logic [31:0]   r_nonce, w_nonce;
  logic [4:0]    r_idx, w_idx;
  logic [1:0]    r_ph, w_ph;
  logic [3:0]    r_ridx, w_ridx;
  logic [2:0]    r_cidx, w_cidx;
  logic          r_armed, w_armed, r_pass, w_pass;
  logic          r_done, w_done, r_found, w_found;
  logic [31:0]   r_nonce_found, w_nonce_found, r_hashes, w_hashes;
  logic          r_sha_start, w_sha_start, r_sha_grant, w_sha_grant, r_mem_we, w_mem_we;
  logic [AW-1:0] r_mem_addr, w_mem_addr;
  logic [31:0]   r_mem_wdata, w_mem_wdata;
  logic          w_job_start;
  logic [3:0]    w_need;
  zc_t           w_zc;

  function automatic logic [31:0] nonce_word(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  hash_zero_check #(.HASH_WORDS(HASH_WORDS)) u_zero_chk (
    .i_word_idx     (r_cidx),
    .i_word         (mem_read_data),
    .i_target_zeros (r_tz),
    .o_result       (w_zc)
  );

  assign w_need = words_needed(r_tz);

  always_comb begin
    w_state = r_state;  w_idx = r_idx;  w_ph = r_ph;
    w_ridx = r_ridx;  w_cidx = r_cidx;  w_armed = r_armed;  w_pass = r_pass;
    w_nonce = r_nonce;  w_done = r_done;  w_found = r_found;
    w_nonce_found = r_nonce_found;  w_hashes = r_hashes;
    w_sha_start = 1'b0;  w_sha_grant = 1'b0;  w_mem_we = 1'b0;
    w_mem_addr = r_mem_addr;  w_mem_wdata = r_mem_wdata;  w_job_start = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_job_start = 1'b1;  w_state = COPY;  w_done = 1'b0;  w_found = 1'b0;
        w_hashes = 32'd0;  w_nonce = nonce_start;  w_idx = 5'd0;  w_ph = 2'd0;
        w_mem_addr = header_addr;
      end
      // Single shared port: header words move in read,read,write,write groups of two.
      COPY: case (r_ph)
        2'd0: begin
          w_ph = 2'd1;
          if (int'(r_idx) + 1 < HDR_WORDS) w_mem_addr = r_hdr_addr + AW'(r_idx) + AW'(1);
        end
        2'd1: begin
          w_ph = 2'd2;  w_mem_we = 1'b1;
          w_mem_addr = r_msg_addr + AW'(r_idx);  w_mem_wdata = mem_read_data;
        end
        2'd2: begin
          if (int'(r_idx) + 1 < HDR_WORDS) begin
            w_ph = 2'd3;  w_mem_we = 1'b1;
            w_mem_addr = r_msg_addr + AW'(r_idx) + AW'(1);  w_mem_wdata = mem_read_data;
          end else w_state = WR_NONCE;
        end
        default: begin
          if (int'(r_idx) + 2 < HDR_WORDS) begin
            w_ph = 2'd0;  w_idx = r_idx + 5'd2;
            w_mem_addr = r_hdr_addr + AW'(r_idx) + AW'(2);
          end else w_state = WR_NONCE;
        end
      endcase
      WR_NONCE: begin w_state = SHA_GO;  w_sha_start = 1'b1;  w_sha_grant = 1'b1; end
      SHA_GO:   begin w_state = SHA_ARM;  w_sha_grant = 1'b1; end
      SHA_ARM:  begin w_state = SHA_WAIT;  w_sha_grant = 1'b1; end
      SHA_WAIT: begin
        if (sha_done) begin
          w_state = RD_HASH;  w_armed = 1'b0;  w_cidx = 3'd0;  w_ridx = 4'd0;
          w_hashes = (r_hashes == 32'hFFFF_FFFF) ? r_hashes : r_hashes + 32'd1;
          if (w_need != 4'd0) begin w_mem_addr = r_hash_addr;  w_ridx = 4'd1; end
        end else w_sha_grant = 1'b1;
      end
      RD_HASH: begin
        w_armed = 1'b1;
        if (w_need == 4'd0) begin
          w_pass = 1'b1;  w_state = CHECK;
        end else begin
          if (r_ridx < w_need) begin
            w_mem_addr = r_hash_addr + AW'(r_ridx);  w_ridx = r_ridx + 4'd1;
          end
          // r_armed marks the first cycle whose read data has arrived.
          if (r_armed) begin
            case (w_zc)
              ZC_PASS: begin w_pass = 1'b1;  w_state = CHECK; end
              ZC_FAIL: begin w_pass = 1'b0;  w_state = CHECK; end
              default: w_cidx = r_cidx + 3'd1;
            endcase
          end
        end
      end
      CHECK: begin
        if (r_pass) begin
          w_found = 1'b1;  w_nonce_found = r_nonce;  w_state = DONE;
        end else if (r_nonce >= r_nonce_end) begin
          w_state = DONE;
        end else begin
          w_nonce = r_nonce + 32'd1;  w_state = WR_NONCE;
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
    if (w_state == WR_NONCE && r_state != WR_NONCE) begin
      w_mem_we = 1'b1;  w_mem_addr = r_msg_addr + AW'(HDR_WORDS);
      w_mem_wdata = nonce_word(w_nonce);
    end
    if (w_state == DONE) w_done = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nonce <= '0;  r_idx <= '0;  r_ph <= '0;  r_ridx <= '0;  r_cidx <= '0;
      r_armed <= 1'b0;  r_pass <= 1'b0;  r_done <= 1'b0;  r_found <= 1'b0;
      r_nonce_found <= '0;  r_hashes <= '0;  r_sha_start <= 1'b0;  r_sha_grant <= 1'b0;
      r_mem_we <= 1'b0;  r_mem_addr <= '0;  r_mem_wdata <= '0;
    end else begin
      r_nonce <= w_nonce;  r_idx <= w_idx;  r_ph <= w_ph;  r_ridx <= w_ridx;  r_cidx <= w_cidx;
      r_armed <= w_armed;  r_pass <= w_pass;  r_done <= w_done;  r_found <= w_found;
      r_nonce_found <= w_nonce_found;  r_hashes <= w_hashes;  r_sha_start <= w_sha_start;
      r_sha_grant <= w_sha_grant;  r_mem_we <= w_mem_we;  r_mem_addr <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hdr_addr <= '0;  r_msg_addr <= '0;  r_hash_addr <= '0;  r_nonce_end <= '0;  r_tz <= '0;
    end else if (w_job_start) begin
      r_hdr_addr <= header_addr;  r_msg_addr <= msg_addr;  r_hash_addr <= hash_addr;
      r_nonce_end <= nonce_end;  r_tz <= target_zeros;
    end
  end

  assign done             = r_done;
  assign found            = r_found;
  assign nonce_found      = r_nonce_found;
  assign hashes_tried     = r_hashes;
  assign sha_start        = r_sha_start;
  assign sha_grant        = r_sha_grant;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_write_data   = r_mem_wdata;
  assign sha_message_addr = msg_addr;
  assign sha_output_addr  = hash_addr;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb/tb_nonce_search_ctrl.sv - self-checking bench for nonce_search_ctrl
module tb_nonce_search_ctrl;
  localparam int AW  = 16;
  localparam int LAT = 6;
  localparam logic [AW-1:0] HDR_BASE  = 16'h0100;
  localparam logic [AW-1:0] MSG_BASE  = 16'h0200;
  localparam logic [AW-1:0] HASH_BASE = 16'h0300;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] header_addr = HDR_BASE, msg_addr = MSG_BASE, hash_addr = HASH_BASE;
  logic [31:0]   nonce_start = '0, nonce_end = '0;
  logic [8:0]    target_zeros = '0;
  logic          done, found, sha_start, sha_grant, mem_we;
  logic [31:0]   nonce_found, hashes_tried, mem_write_data;
  logic [AW-1:0] sha_message_addr, sha_output_addr, mem_addr;
  logic          sha_done = 1'b0;
  logic [31:0]   mem_read_data = '0;

  logic [31:0] mem [0:65535];
  logic        start_d1 = 1'b0;
  logic [31:0] hs_nonce = '0;
  logic [31:0] last_nonce_wr = '0;
  int          busy_cnt = 0;
  int          sha_pulses = 0;
  int          checks = 0;
  int          errors = 0;
  logic        exp_valid = 1'b0;
  logic        grant_chk = 1'b1;
  logic        exp_found = 1'b0;
  logic [31:0] exp_nf = '0, exp_tried = '0;

  always #5 clk = ~clk;

  nonce_search_ctrl #(.HDR_WORDS(19), .HASH_WORDS(8), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .header_addr(header_addr),
    .msg_addr(msg_addr), .hash_addr(hash_addr), .nonce_start(nonce_start),
    .nonce_end(nonce_end), .target_zeros(target_zeros), .done(done), .found(found),
    .nonce_found(nonce_found), .hashes_tried(hashes_tried), .sha_start(sha_start),
    .sha_message_addr(sha_message_addr), .sha_output_addr(sha_output_addr),
    .sha_done(sha_done), .sha_grant(sha_grant), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] hdr_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] nw(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  function automatic logic [31:0] hash_of(input logic [31:0] n, input int i);
    if (n == 32'h50) return 32'd0;
    if (n == 32'd7 && i == 0) return 32'h0000_1234;
    if (n == 32'd12) return (i == 0) ? 32'd0 : (i == 1) ? 32'h00AB_CDEF : 32'hFFFF_0000;
    if (n == 32'h1122_3344 && i == 0) return 32'h0000_0001;
    if (i == 0) return 32'h8000_0000 | n;
    return (32'h9E37_79B9 * 32'(i)) ^ n;
  endfunction

  // Leading zeros of the whole 256-bit digest, word 0 most significant.
  function automatic int lz256(input logic [31:0] n);
    logic [31:0] w;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      w = hash_of(n, i);
      for (int b = 31; b >= 0; b--) begin
        if (w[b]) return cnt;
        cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic model_job(input logic [31:0] ns, input logic [31:0] ne, input int tz,
                           output logic f, output logic [31:0] nf, output logic [31:0] tried);
    logic [31:0] n;
    n = ns;  f = 1'b0;  nf = '0;  tried = '0;
    for (int k = 0; k < 4096; k++) begin
      tried++;
      if (lz256(n) >= tz) begin f = 1'b1;  nf = n;  break; end
      if (n >= ne) break;
      n++;
    end
  endtask

  // Synchronous memory (two-edge read latency) plus behavioural hasher.
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we && !sha_grant) begin
      mem[mem_addr] = mem_write_data;
      if (mem_addr == MSG_BASE + 16'd19) last_nonce_wr <= mem_write_data;
    end
    start_d1 <= sha_start;
    if (start_d1) sha_done <= 1'b0;
    if (sha_start) begin
      sha_pulses++;
      hs_nonce = nw(mem[sha_message_addr + 16'd19]);
      busy_cnt = LAT;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        for (int i = 0; i < 8; i++) mem[sha_output_addr + 16'(i)] = hash_of(hs_nonce, i);
        sha_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (mem_we && sha_grant) begin
        errors++;
        $display("FAIL bus_owner: mem_we=%0b with sha_grant=%0b, required mem_we=0", mem_we, sha_grant);
      end
      if (grant_chk && busy_cnt > 0) begin
        checks++;
        if (sha_grant !== 1'b1) begin
          errors++;
          $display("FAIL grant_busy: sha_grant=%0b while hasher busy, required 1", sha_grant);
        end
      end
      if (exp_valid && done) begin
        checks++;
        if (found !== exp_found || hashes_tried !== exp_tried || (exp_found && nonce_found !== exp_nf)) begin
          errors++;
          $display("FAIL model_result: found=%0b nonce=0x%08h tried=%0d, required found=%0b nonce=0x%08h tried=%0d",
                   found, nonce_found, hashes_tried, exp_found, exp_nf, exp_tried);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input logic v);
    bit got;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (sha_grant === v) got = 1;
    end
    chk("grant_wait", 32'(got), 32'd1);
  endtask

  task automatic run_job(input logic [31:0] ns, input logic [31:0] ne, input logic [8:0] tz,
                         input logic lit_found, input logic [31:0] lit_nf, input logic [31:0] lit_tried);
    logic mf;
    logic [31:0] mnf, mtried;
    int base;
    bit got;
    model_job(ns, ne, int'(tz), mf, mnf, mtried);
    exp_valid = 1'b0;
    exp_found = mf;  exp_nf = mnf;  exp_tried = mtried;
    @(negedge clk);
    nonce_start = ns;  nonce_end = ne;  target_zeros = tz;  start = 1'b1;
    base = sha_pulses;
    @(negedge clk);
    start = 1'b0;
    chk("done_cleared", 32'(done), 32'd0);
    exp_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_timeout", 32'(got), 32'd1);
    chk("found", 32'(found), 32'(lit_found));
    if (lit_found) chk("nonce_found", nonce_found, lit_nf);
    chk("hashes_tried", hashes_tried, lit_tried);
    chk("sha_pulses", 32'(sha_pulses - base), lit_tried);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD_BEEF;
    for (int i = 0; i < 19; i++) mem[HDR_BASE + 16'(i)] = hdr_word(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {27'd0, done, found, sha_start, sha_grant, mem_we}, 32'd0);
    chk("rst_nonce_found", nonce_found, 32'd0);
    chk("rst_tried", hashes_tried, 32'd0);
    chk("rst_mem", {16'd0, mem_addr} | mem_write_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_job(32'd5, 32'd20, 9'd0, 1'b1, 32'd5, 32'd1);
    run_job(32'd3, 32'd10, 9'd16, 1'b1, 32'd7, 32'd5);
    for (int i = 0; i < 19; i++) chk($sformatf("hdr_copy_%0d", i), mem[MSG_BASE + 16'(i)], hdr_word(i));
    chk("last_nonce_hit", last_nonce_wr, nw(32'd7));
    run_job(32'd3, 32'd10, 9'd20, 1'b0, 32'd0, 32'd8);
    chk("last_nonce_miss", last_nonce_wr, nw(32'd10));
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 9'd20, 1'b0, 32'd0, 32'd1);
    chk("last_nonce_top", last_nonce_wr, nw(32'hFFFF_FFFF));
    run_job(32'd9, 32'd4, 9'd20, 1'b0, 32'd0, 32'd1);
    run_job(32'd11, 32'd13, 9'd40, 1'b1, 32'd12, 32'd2);
    run_job(32'd11, 32'd13, 9'd41, 1'b0, 32'd0, 32'd3);
    run_job(32'h4F, 32'h50, 9'd256, 1'b1, 32'h50, 32'd2);

    exp_valid = 1'b0;
    grant_chk = 1'b0;
    @(negedge clk);
    nonce_start = 32'd3;  nonce_end = 32'd10;  target_zeros = 9'd20;  start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_grant(1'b1);
    wait_grant(1'b0);
    wait_grant(1'b1);
    repeat (2) @(negedge clk);
    chk("pre_reset_tried", hashes_tried, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_flags", {27'd0, done, found, sha_start, sha_grant, mem_we}, 32'd0);
    chk("async_rst_tried", hashes_tried, 32'd0);
    chk("async_rst_mem", {16'd0, mem_addr} | mem_write_data, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    grant_chk = 1'b1;
    run_job(32'd3, 32'd10, 9'd16, 1'b1, 32'd7, 32'd5);

    run_job(32'h1122_3344, 32'h1122_3344, 9'd31, 1'b1, 32'h1122_3344, 32'd1);
`ifdef NONCE_BSWAP_EN
    chk("nonce_word19", mem[MSG_BASE + 16'd19], 32'h4433_2211);
`else
    chk("nonce_word19", mem[MSG_BASE + 16'd19], 32'h1122_3344);
`endif

    exp_valid = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
